// File: rtl/calc_pkg.sv
// Shared calculator definitions: sequencer states, operator encoding and the
// common number width used by the entry FSM, adder and display controller.
package calc_pkg;

  localparam int CALC_W = 10;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // A subtract is a + ~b + 1, so its final carry is the inverse of the borrow.
  function automatic logic carry_to_flag(input logic op, input logic carry);
    return (op == OP_SUB) ? ~carry : carry;
  endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full-adder slice driven LSB-first by the serial adder sequencer.
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: accepts operands on start, streams them
// through a single full-adder slice LSB-first and reports sum plus carry/borrow.
module serial_add_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_W,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             flag
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             flag_q, flag_d;
  logic             op_q, op_d;

  logic fa_s;
  logic fa_cout;
  logic accept;

  serial_fa_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Start is only honoured when no operation is in flight.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    flag_d  = flag_q;
    op_d    = op_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_d     = a;
          b_d     = (op == OP_SUB) ? ~b : b;
          op_d    = op;
          carry_d = op;
          cnt_d   = '0;
          res_d   = '0;
          flag_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          flag_d  = carry_to_flag(op_q, fa_cout);
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      flag_q  <= flag_d;
    end
  end

  // Operand shifters and the latched operator carry no reset; they are
  // always reloaded on accept before being consumed.
  always_ff @(posedge clk_in) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = res_q;
  assign flag = flag_q;

  a_busy_done_excl: assert property (@(posedge clk_in) disable iff (rst) !(busy && done));
  a_done_follows_last_bit: assert property (@(posedge clk_in) disable iff (rst)
    (busy && (cnt_q == LAST_CNT)) |=> done);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: arithmetic reference model with a per-cycle
// compare, directed literal scenarios and a randomized stimulus phase.
module tb_serial_add_ctrl;
  import calc_pkg::*;

  localparam int W = 10;
  localparam int MASK = (1 << W) - 1;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = OP_ADD;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         flag;

  int n_checks = 0;
  int n_fail = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .flag   (flag)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: rem = -1 idle, 0 result cycle, >0 bits still to shift.
  int rem = -1;
  int exp_sum = 0;
  int exp_flag = 0;
  int pend_sum = 0;
  int pend_flag = 0;

  always @(posedge clk_in) begin
    if (rst) begin
      rem = -1;
      exp_sum = 0;
      exp_flag = 0;
    end else if (rem <= 0 && start) begin
      rem = W;
      if (op == OP_SUB) begin
        pend_sum  = (int'(a) - int'(b)) & MASK;
        pend_flag = (int'(a) < int'(b)) ? 1 : 0;
      end else begin
        pend_sum  = (int'(a) + int'(b)) & MASK;
        pend_flag = ((int'(a) + int'(b)) > MASK) ? 1 : 0;
      end
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) begin
        exp_sum = pend_sum;
        exp_flag = pend_flag;
      end
    end else begin
      rem = -1;
    end
  end

  always @(negedge clk_in) begin
    chk("busy", int'(busy), (rem > 0) ? 1 : 0);
    chk("done", int'(done), (rem == 0) ? 1 : 0);
    if (rem <= 0) begin
      chk("sum", int'(sum), exp_sum);
      chk("flag", int'(flag), exp_flag);
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(MASK);
      2: return W'(1);
      default: return W'($urandom_range(0, MASK));
    endcase
  endfunction

  // Called at a negedge; the following posedge is the accept edge.
  task automatic go(input int av, input int bv, input logic opv);
    a = W'(av);
    b = W'(bv);
    op = opv;
    start = 1'b1;
  endtask

  // Counts posedges from the accept edge until done is seen, counting busy
  // cycles on the way; optionally pokes a second start at a given bit.
  task automatic wait_done(output int edges, output int busy_n, input int poke);
    edges = 0;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in);
      edges++;
      @(negedge clk_in);
      if (edges == poke) begin
        start = 1'b1;
        a = W'(1);
        b = W'(1);
        op = OP_SUB;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (done) return;
    end
    chk("done_timeout", edges, -1);
  endtask

  task automatic lit_op(input string name, input int av, input int bv, input logic opv,
                        input int s_exp, input int f_exp, input int poke);
    int edges;
    int busy_n;
    go(av, bv, opv);
    wait_done(edges, busy_n, poke);
    chk({name, "_latency"}, edges, W + 1);
    chk({name, "_busy_cycles"}, busy_n, W);
    chk({name, "_sum"}, int'(sum), s_exp);
    chk({name, "_flag"}, int'(flag), f_exp);
    chk({name, "_model_sum"}, exp_sum, s_exp);
    chk({name, "_model_flag"}, exp_flag, f_exp);
  endtask

  initial begin
    int edges;
    int busy_n;
    bit saw_done;

    // Reset held with start asserted must not launch an operation.
    start = 1'b1;
    a = W'(5);
    b = W'(3);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_flag", int'(flag), 0);
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("post_rst_busy", int'(busy), 0);

    lit_op("add_123_456", 123, 456, OP_ADD, 579, 0, 0);
    @(negedge clk_in);
    chk("done_one_cycle", int'(done), 0);
    lit_op("add_1000_100", 1000, 100, OP_ADD, 76, 1, 0);
    @(negedge clk_in);
    lit_op("add_1023_1", 1023, 1, OP_ADD, 0, 1, 0);
    @(negedge clk_in);
    lit_op("sub_9_5", 9, 5, OP_SUB, 4, 0, 0);
    @(negedge clk_in);
    lit_op("sub_5_9", 5, 9, OP_SUB, 1020, 1, 0);
    @(negedge clk_in);
    lit_op("sub_0_0", 0, 0, OP_SUB, 0, 0, 0);
    @(negedge clk_in);

    // Start pulsed mid-SHIFT with new operands is ignored.
    lit_op("ignore_mid", 123, 456, OP_ADD, 579, 0, 4);
    // Start held in the DONE cycle re-accepts immediately.
    lit_op("b2b_2_3", 2, 3, OP_ADD, 5, 0, 0);
    @(negedge clk_in);

    // Reset at bit 5 of 300+300 discards the operation.
    go(300, 300, OP_ADD);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sum", int'(sum), 0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", int'(saw_done), 0);
    lit_op("after_rst_7_8", 7, 8, OP_ADD, 15, 0, 0);
    @(negedge clk_in);

    // Randomized traffic; the per-cycle compare against the model does the checking.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      rst = ($urandom_range(0, 249) == 0);
      start = ($urandom_range(0, 3) == 0);
      op = ($urandom_range(0, 1) == 1) ? OP_SUB : OP_ADD;
      a = pick();
      b = pick();
    end
    @(negedge clk_in);
    rst = 1'b0;
    start = 1'b0;
    repeat (W + 4) @(negedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
